// File: rtl/wb_cmd_master.sv
// +--------------------------------------------------------------------------+
// | wb_cmd_master: Wishbone B3 classic single-transaction initiator with     |
// | wait states, retry back-off, bus error and no-response timeout.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_cmd_master #(
  parameter int WB_AW     = 32,
  parameter int WB_DW     = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [WB_AW-1:0]   cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  input  logic [WB_DW/8-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               rsp_tmo_o,
  output logic [WB_AW-1:0]   wb_adr_o,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic [WB_DW/8-1:0] wb_sel_o,
  output logic               wb_we_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  input  logic               wb_rty_i,
  output logic               busy_o
);

  localparam int SW = WB_DW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
  localparam logic [RW-1:0] RTY_LIMIT = RW'(MAX_RETRY);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUS     = 2'd1;
  localparam logic [1:0] S_BACKOFF = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [WB_AW-1:0] adr_q, adr_d;
  logic [WB_DW-1:0] dat_q, dat_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             we_q, we_d;
  logic             cyc_q, cyc_d;
  logic [WB_DW-1:0] rdat_q, rdat_d;
  logic             rerr_q, rerr_d;
  logic             rtmo_q, rtmo_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      rcnt_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      rtmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      rcnt_q  <= rcnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      rtmo_q  <= rtmo_d;
    end
  end

  // Slave responses are prioritised err > ack > rty > timeout.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_BUS;
          tcnt_d  = '0;
          rcnt_d  = '0;
        end
      end
      S_BUS: begin
        if (wb_err_i || wb_ack_i) begin
          state_d = S_RESP;
        end else if (wb_rty_i) begin
          if (rcnt_q < RTY_LIMIT) begin
            rcnt_d  = rcnt_q + 1'b1;
            state_d = S_BACKOFF;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_d == TMO_LIMIT) state_d = S_RESP;
        end
      end
      S_BACKOFF: begin
        tcnt_d  = '0;
        state_d = S_BUS;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    adr_d  = adr_q;
    dat_d  = dat_q;
    sel_d  = sel_q;
    we_d   = we_q;
    rdat_d = rdat_q;
    rerr_d = rerr_q;
    rtmo_d = rtmo_q;
    if (state_q == S_IDLE && cmd_valid_i) begin
      adr_d = cmd_adr_i;
      dat_d = cmd_dat_i;
      sel_d = cmd_sel_i;
      we_d  = cmd_we_i;
    end
    if (state_q == S_BUS && state_d == S_RESP) begin
      we_d   = 1'b0;
      rdat_d = '0;
      rerr_d = 1'b0;
      rtmo_d = 1'b0;
      if (wb_err_i)       rerr_d = 1'b1;
      else if (wb_ack_i)  rdat_d = we_q ? '0 : wb_dat_i;
      else if (wb_rty_i)  rerr_d = 1'b1;
      else                rtmo_d = 1'b1;
    end
    if (state_q == S_RESP && rsp_ready_i) begin
      rdat_d = '0;
      rerr_d = 1'b0;
      rtmo_d = 1'b0;
    end
  end

  assign cyc_d       = (state_d == S_BUS);
  assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == S_RESP);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_dat_o   = rdat_q;
  assign rsp_err_o   = rerr_q;
  assign rsp_tmo_o   = rtmo_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// +--------------------------------------------------------------------------+
// | tb_wb_cmd_master: directed vectors against a configurable Wishbone slave |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_cmd_master;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_ERRACK = 2;
  localparam int K_SILENT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_tmo_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic        busy_o;

  wb_cmd_master #(.WB_AW(32), .WB_DW(32), .TIMEOUT(8), .MAX_RETRY(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave: answers after cfg_waits stb cycles, with cfg_rty_n leading retries.
  int          cfg_waits = 0;
  int          cfg_rty_n = 0;
  int          cfg_kind  = K_ACK;
  logic [31:0] cfg_rdata = '0;
  int          slv_wait;
  int          slv_att;
  logic [31:0] leds;
  logic        resp_now;

  assign resp_now = wb_cyc_o && wb_stb_o && (slv_wait == cfg_waits) && (cfg_kind != K_SILENT);
  assign wb_rty_i = resp_now && (slv_att < cfg_rty_n);
  assign wb_ack_i = resp_now && !wb_rty_i && (cfg_kind == K_ACK || cfg_kind == K_ERRACK);
  assign wb_err_i = resp_now && !wb_rty_i && (cfg_kind == K_ERR || cfg_kind == K_ERRACK);
  assign wb_dat_i = cfg_rdata;

  always @(posedge clk_i) begin
    if (rst_i) begin
      slv_wait <= 0;
      slv_att  <= 0;
      leds     <= '0;
    end else begin
      if (wb_cyc_o && wb_stb_o && !resp_now) slv_wait <= slv_wait + 1;
      else                                   slv_wait <= 0;
      if (!busy_o)                 slv_att <= 0;
      else if (wb_rty_i)           slv_att <= slv_att + 1;
      if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o && wb_adr_o == 32'h0)
        for (int b = 0; b < 4; b++)
          if (wb_sel_o[b]) leds[b*8 +: 8] <= wb_dat_o[b*8 +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    int          rty_n;
    int          kind;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_stb;
    int          exp_gap;
    int          hold;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int  stb_cnt = 0;
    int  gap_cnt = 0;
    logic bad = 1'b0;
    logic done = 1'b0;
    @(negedge clk_i);
    cfg_waits   = v.waits;
    cfg_rty_n   = v.rty_n;
    cfg_kind    = v.kind;
    cfg_rdata   = v.rdata;
    cmd_we_i    = v.we;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    cmd_sel_i   = v.sel;
    cmd_valid_i = 1'b1;
    rsp_ready_i = (v.hold == 0);
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        done = 1'b1;
        break;
      end
      if (wb_stb_o) begin
        stb_cnt++;
        if (!wb_cyc_o || wb_adr_o !== v.adr || wb_we_o !== v.we || wb_sel_o !== v.sel ||
            (v.we && wb_dat_o !== v.dat)) bad = 1'b1;
      end
      if (busy_o && !wb_cyc_o) gap_cnt++;
    end
    check({tag, "_rsp_seen"}, 64'(done), 64'd1);
    for (int h = 0; h < v.hold; h++) begin
      check($sformatf("%s_hold%0d", tag, h),
            64'({rsp_valid_o, cmd_ready_o, rsp_err_o, rsp_tmo_o, rsp_dat_o}),
            64'({1'b1, 1'b0, v.exp_err, v.exp_tmo, v.exp_dat}));
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    check({tag, "_dat"}, 64'(rsp_dat_o), 64'(v.exp_dat));
    check({tag, "_err"}, 64'(rsp_err_o), 64'(v.exp_err));
    check({tag, "_tmo"}, 64'(rsp_tmo_o), 64'(v.exp_tmo));
    check({tag, "_stb_cycles"}, 64'(stb_cnt), 64'(v.exp_stb));
    check({tag, "_cyc_gaps"}, 64'(gap_cnt), 64'(v.exp_gap));
    check({tag, "_bus_stable"}, 64'(bad), 64'd0);
    @(posedge clk_i);
    #1;
    check({tag, "_ready_after"}, 64'({cmd_ready_o, rsp_valid_o, wb_cyc_o}), 64'b100);
  endtask

  vec_t vecs[9];
  vec_t wv;

  initial begin
    //           we    adr       dat       sel  wt rty kind       rdata         exp_dat       err   tmo  stb gap hold
    vecs[0] = '{1'b1, 32'h0,    32'h15,   4'hF, 0, 0, K_ACK,    32'h0,        32'h0,        1'b0, 1'b0, 1, 0, 0};
    vecs[1] = '{1'b0, 32'h10,   32'h0,    4'hF, 3, 0, K_ACK,    32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 4, 0, 0};
    vecs[2] = '{1'b0, 32'h14,   32'h0,    4'hF, 1, 0, K_ERRACK, 32'h12345678, 32'h0,        1'b1, 1'b0, 2, 0, 0};
    vecs[3] = '{1'b0, 32'h18,   32'h0,    4'hF, 0, 2, K_ACK,    32'hA5A50001, 32'hA5A50001, 1'b0, 1'b0, 3, 2, 0};
    vecs[4] = '{1'b1, 32'h1C,   32'h55,   4'h1, 0, 4, K_ACK,    32'h0,        32'h0,        1'b1, 1'b0, 4, 3, 0};
    vecs[5] = '{1'b0, 32'h20,   32'h0,    4'hF, 0, 0, K_SILENT, 32'h77777777, 32'h0,        1'b0, 1'b1, 8, 0, 5};
    vecs[6] = '{1'b0, 32'h24,   32'h0,    4'hF, 7, 0, K_ACK,    32'h0000CAFE, 32'h0000CAFE, 1'b0, 1'b0, 8, 0, 0};
    vecs[7] = '{1'b1, 32'h28,   32'h99,   4'hC, 2, 0, K_ERR,    32'h0,        32'h0,        1'b1, 1'b0, 3, 0, 0};
    vecs[8] = '{1'b0, 32'h2C,   32'h0,    4'h3, 0, 0, K_ACK,    32'h0000BEEF, 32'h0000BEEF, 1'b0, 1'b0, 1, 0, 2};

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs",
          64'({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_tmo_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    check("reset_bus_data", 64'({wb_adr_o, wb_sel_o} | {4'h0, rsp_dat_o}), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1 check("ready_after_reset", 64'(cmd_ready_o), 64'd1);

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
      if (i == 0) check("leds_after_write", 64'(leds), 64'h15);
    end

    // Reset asserted on the second stb cycle of a read with wait states.
    @(negedge clk_i);
    cfg_waits = 5; cfg_rty_n = 0; cfg_kind = K_ACK; cfg_rdata = 32'h0BADF00D;
    cmd_we_i = 1'b0; cmd_adr_i = 32'h30; cmd_sel_i = 4'hF; cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("mid_read_stb", 64'({wb_cyc_o, wb_stb_o}), 64'b11);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("abort_ctrl",
          64'({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_tmo_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    check("abort_data", 64'({wb_adr_o, wb_sel_o} | {4'h0, rsp_dat_o} | {4'h0, wb_dat_o}), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i);
      #1 check($sformatf("post_abort_idle%0d", c), 64'({cmd_ready_o, rsp_valid_o, wb_cyc_o}), 64'b100);
    end

    wv = '{1'b1, 32'h0, 32'h000000A3, 4'h1, 0, 0, K_ACK, 32'h0, 32'h0, 1'b0, 1'b0, 1, 0, 0};
    run_vec("post_abort_write", wv);
    check("leds_after_abort", 64'(leds), 64'hA3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
